// File: rtl/vga_cram_pkg.sv
// Shared definitions for the text-mode character/colour RAM write controller:
// bus decode constants, register offsets, command codes, controller states,
// default geometry and the row wrap helper used by the controller and the engine.
package vga_cram_pkg;

  // Default visible geometry in character cells.
  localparam int DEF_COLS = 40;
  localparam int DEF_ROWS = 30;

  // sys_addr[15:14] value selecting the controller, sys_addr[13] value selecting registers.
  localparam logic [1:0] VGA_REGION = 2'b01;
  localparam logic       REG_SEL    = 1'b1;

  // Register offsets within the register window (sys_addr[1:0]).
  localparam logic [1:0] REG_CMD        = 2'd0;
  localparam logic [1:0] REG_FILL_CHAR  = 2'd1;
  localparam logic [1:0] REG_FILL_COLOR = 2'd2;
  localparam logic [1:0] REG_ROW_SEL    = 2'd3;

  // Command codes written to REG_CMD.
  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_CLRROW = 8'h02;
  localparam logic [7:0] CMD_SCROLL = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Reduce a 7-bit sum of two in-range row numbers modulo rows.
  // Both operands are below rows, so one conditional subtract is enough.
  function automatic logic [5:0] wrap_row(input logic [6:0] sum, input logic [6:0] rows);
    if (sum >= rows) begin
      return 6'(sum - rows);
    end else begin
      return sum[5:0];
    end
  endfunction

endpackage

// File: rtl/vga_cram_if.sv
// Bus bundle between the 6502-side write logic and the character/colour RAM
// write port.
//   sys_addr/sys_data/sys_we : CPU write bus (driven by the master)
//   ram_addr/ram_data/ram_we : registered RAM write port (driven by the slave)
//   row_base                 : hardware scroll offset (physical row of logical row 0)
//   busy/done                : fill command status
interface vga_cram_if;
  logic [15:0] sys_addr;
  logic [7:0]  sys_data;
  logic        sys_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic [5:0]  row_base;
  logic        busy;
  logic        done;

  modport master (
    output sys_addr, sys_data, sys_we,
    input  ram_addr, ram_data, ram_we, row_base, busy, done
  );

  modport slave (
    input  sys_addr, sys_data, sys_we,
    output ram_addr, ram_data, ram_we, row_base, busy, done
  );
endinterface

// File: rtl/vga_fill_engine.sv
// Fill sequencer: walks rows ascending from start_row, columns 0..COLS-1,
// emitting plane 0 (fill_char) then plane 1 (fill_color) for each cell.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   load                  : load counters and start a run
//   stall                 : hold counters (RAM port used by the CPU this cycle)
//   start_row, row_count  : first physical row and number of rows to fill
//   fill_char, fill_color : data for plane 0 / plane 1 (held stable by the caller)
//   addr, data            : current write {plane, row, col} and its data
//   valid                 : a write is pending
//   last                  : the pending write is the final one of the run
module vga_fill_engine
  import vga_cram_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        stall,
  input  logic [5:0]  start_row,
  input  logic [6:0]  row_count,
  input  logic [7:0]  fill_char,
  input  logic [7:0]  fill_color,
  output logic [12:0] addr,
  output logic [7:0]  data,
  output logic        valid,
  output logic        last
);
  localparam logic [5:0] COL_LAST = 6'(COLS - 1);
  localparam logic [6:0] ROWS_W   = 7'(ROWS);

  logic       active_r;
  logic       plane_r;
  logic [5:0] col_r;
  logic [5:0] row_r;
  logic [6:0] rows_left_r;
  logic       row_end_s;
  logic       advance_s;

  assign row_end_s = plane_r && (col_r == COL_LAST);
  assign advance_s = active_r && !stall;
  assign last      = active_r && row_end_s && (rows_left_r == 7'd1);
  assign valid     = active_r;
  assign addr      = {plane_r, row_r, col_r};
  assign data      = plane_r ? fill_color : fill_char;

  // Plane/column/row counters; a stalled cycle leaves every counter untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r    <= 1'b0;
      plane_r     <= 1'b0;
      col_r       <= 6'd0;
      row_r       <= 6'd0;
      rows_left_r <= 7'd0;
    end else if (load) begin
      active_r    <= (row_count != 7'd0);
      plane_r     <= 1'b0;
      col_r       <= 6'd0;
      row_r       <= start_row;
      rows_left_r <= row_count;
    end else if (advance_s) begin
      if (!plane_r) begin
        plane_r <= 1'b1;
      end else begin
        plane_r <= 1'b0;
        if (col_r == COL_LAST) begin
          col_r       <= 6'd0;
          row_r       <= wrap_row({1'b0, row_r} + 7'd1, ROWS_W);
          rows_left_r <= rows_left_r - 7'd1;
          if (rows_left_r == 7'd1) begin
            active_r <= 1'b0;
          end
        end else begin
          col_r <= col_r + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_cram_ctrl.sv
// Write-side controller for the text-mode character/colour RAM.
// Passes CPU cell writes through (logical row translated by row_base), holds
// the FILL_CHAR/FILL_COLOR/ROW_SEL registers and runs CLEAR/CLRROW/SCROLL fill
// commands on the shared RAM write port; CPU cell writes always win the port.
// Ports:
//   sys_clk : system clock (rising edge)
//   reset   : asynchronous active-high reset
//   bus     : vga_cram_if.slave (CPU write bus in, RAM write port and status out)
module vga_cram_ctrl
  import vga_cram_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input logic       sys_clk,
  input logic       reset,
  vga_cram_if.slave bus
);
  localparam logic [6:0] ROWS_W = 7'(ROWS);

  // Decode
  logic        region_s;
  logic        cell_we_s;
  logic        reg_we_s;
  logic [5:0]  lrow_s;
  logic [5:0]  phys_row_s;
  logic [12:0] cpu_addr_s;

  // Registers and latched job
  logic [7:0] fill_char_r;
  logic [7:0] fill_color_r;
  logic [7:0] row_sel_r;
  logic [5:0] row_base_r;
  logic [7:0] job_char_r;
  logic [7:0] job_color_r;
  logic [5:0] job_row_r;
  logic [6:0] job_count_r;

  // Command acceptance
  logic       cmd_ok_s;
  logic [5:0] new_base_s;
  logic [5:0] start_row_s;
  logic [6:0] row_count_s;

  // FSM and engine
  state_t      state_r;
  state_t      next_state_s;
  logic        eng_load_s;
  logic [12:0] eng_addr_s;
  logic [7:0]  eng_data_s;
  logic        eng_valid_s;
  logic        eng_last_s;

  // Output registers
  logic [12:0] ram_addr_r;
  logic [7:0]  ram_data_r;
  logic        ram_we_r;
  logic        busy_r;
  logic        done_r;

  assign region_s   = bus.sys_we && (bus.sys_addr[15:14] == VGA_REGION);
  assign cell_we_s  = region_s && (bus.sys_addr[13] != REG_SEL);
  assign reg_we_s   = region_s && (bus.sys_addr[13] == REG_SEL);
  assign lrow_s     = bus.sys_addr[11:6];
  assign cpu_addr_s = {bus.sys_addr[12], phys_row_s, bus.sys_addr[5:0]};
  assign eng_load_s = (state_r == ST_SETUP);

  // Logical-to-physical row translation; rows beyond the screen pass through unwrapped.
  always_comb begin
    phys_row_s = lrow_s;
    if ({1'b0, lrow_s} < ROWS_W) begin
      phys_row_s = wrap_row({1'b0, lrow_s} + {1'b0, row_base_r}, ROWS_W);
    end else begin
      phys_row_s = lrow_s;
    end
  end

  // Command decode: decides acceptance, the new scroll base and the rows to fill.
  always_comb begin
    cmd_ok_s    = 1'b0;
    new_base_s  = row_base_r;
    start_row_s = 6'd0;
    row_count_s = 7'd0;
    if (reg_we_s && (bus.sys_addr[1:0] == REG_CMD) && (state_r == ST_IDLE)) begin
      case (bus.sys_data)
        CMD_CLEAR: begin
          cmd_ok_s    = 1'b1;
          new_base_s  = 6'd0;
          start_row_s = 6'd0;
          row_count_s = ROWS_W;
        end
        CMD_CLRROW: begin
          if (row_sel_r < {1'b0, ROWS_W}) begin
            cmd_ok_s    = 1'b1;
            start_row_s = wrap_row({1'b0, row_sel_r[5:0]} + {1'b0, row_base_r}, ROWS_W);
            row_count_s = 7'd1;
          end else begin
            cmd_ok_s = 1'b0;
          end
        end
        CMD_SCROLL: begin
          // The old top row becomes the new bottom row and is the one cleared.
          cmd_ok_s    = 1'b1;
          new_base_s  = wrap_row({1'b0, row_base_r} + 7'd1, ROWS_W);
          start_row_s = row_base_r;
          row_count_s = 7'd1;
        end
        default: begin
          cmd_ok_s = 1'b0;
        end
      endcase
    end else begin
      cmd_ok_s = 1'b0;
    end
  end

  // Register file, scroll base and job latch (fill values frozen at acceptance).
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      fill_char_r  <= 8'd0;
      fill_color_r <= 8'd0;
      row_sel_r    <= 8'd0;
      row_base_r   <= 6'd0;
      job_char_r   <= 8'd0;
      job_color_r  <= 8'd0;
      job_row_r    <= 6'd0;
      job_count_r  <= 7'd0;
    end else begin
      if (reg_we_s) begin
        case (bus.sys_addr[1:0])
          REG_FILL_CHAR:  fill_char_r  <= bus.sys_data;
          REG_FILL_COLOR: fill_color_r <= bus.sys_data;
          REG_ROW_SEL:    row_sel_r    <= bus.sys_data;
          default:        ;
        endcase
      end
      if (cmd_ok_s) begin
        row_base_r  <= new_base_s;
        job_char_r  <= fill_char_r;
        job_color_r <= fill_color_r;
        job_row_r   <= start_row_s;
        job_count_r <= row_count_s;
      end
    end
  end

  // Command FSM state register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Command FSM next state; the final fill write only counts when not pre-empted by the CPU.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_ok_s) begin
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP: next_state_s = ST_FILL;
      ST_FILL: begin
        if (eng_last_s && !cell_we_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_FILL;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  vga_fill_engine #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_engine (
    .clk        (sys_clk),
    .reset      (reset),
    .load       (eng_load_s),
    .stall      (cell_we_s),
    .start_row  (job_row_r),
    .row_count  (job_count_r),
    .fill_char  (job_char_r),
    .fill_color (job_color_r),
    .addr       (eng_addr_s),
    .data       (eng_data_s),
    .valid      (eng_valid_s),
    .last       (eng_last_s)
  );

  // RAM port mux and output registers; status flags follow the next FSM state.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ram_addr_r <= 13'd0;
      ram_data_r <= 8'd0;
      ram_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r <= (next_state_s != ST_IDLE);
      done_r <= (next_state_s == ST_DONE);
      if (cell_we_s) begin
        ram_addr_r <= cpu_addr_s;
        ram_data_r <= bus.sys_data;
        ram_we_r   <= 1'b1;
      end else if (eng_valid_s) begin
        ram_addr_r <= eng_addr_s;
        ram_data_r <= eng_data_s;
        ram_we_r   <= 1'b1;
      end else begin
        ram_we_r <= 1'b0;
      end
    end
  end

  assign bus.ram_addr = ram_addr_r;
  assign bus.ram_data = ram_data_r;
  assign bus.ram_we   = ram_we_r;
  assign bus.row_base = row_base_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_vga_cram_ctrl.sv
// Self-checking bench for vga_cram_ctrl: stimulus pushes expected RAM writes
// into a queue, a negedge monitor pops and compares every ram_we cycle.
module tb_vga_cram_ctrl;
  import vga_cram_pkg::*;

  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_cram_if bus ();

  vga_cram_ctrl #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [7:0]  cur_char  = 8'h00;
  logic [7:0]  cur_color = 8'h00;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] fcell(input int plane, input int row, input int col, input logic [7:0] d);
    return {1'(plane), 6'(row), 6'(col), d};
  endfunction

  // Scoreboard monitor: every RAM write must match the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [20:0] e;
    if (bus.ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_write", {11'd0, bus.ram_addr, bus.ram_data}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({bus.ram_addr, bus.ram_data} == e, "ram_write",
              {11'd0, bus.ram_addr, bus.ram_data}, {11'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.sys_addr = a;
    bus.sys_data = d;
    bus.sys_we   = 1'b1;
    @(posedge clk);
    #1;
    bus.sys_we = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] off, input logic [7:0] d);
    cpu_write({14'h1800, off}, d);
  endtask

  task automatic cell_write(input logic [15:0] a, input logic [7:0] d, input logic [12:0] exp_addr);
    exp_q.push_back({exp_addr, d});
    cpu_write(a, d);
    check(bus.ram_we && bus.ram_addr == exp_addr && bus.ram_data == d, "cell_write_timing",
          {bus.ram_we, 10'd0, bus.ram_addr, bus.ram_data}, {1'b1, 10'd0, exp_addr, d});
  endtask

  task automatic set_fill(input logic [7:0] ch, input logic [7:0] co);
    reg_write(REG_FILL_CHAR, ch);
    reg_write(REG_FILL_COLOR, co);
    cur_char  = ch;
    cur_color = co;
  endtask

  // Issue an uncontended fill command, optionally with one register write injected mid-fill.
  task automatic do_cmd(input logic [7:0] code, input int start_row, input int nrows, input int exp_base,
                        input bit inject, input logic [15:0] inj_addr, input logic [7:0] inj_data);
    int  k;
    bit  seen;
    int  want;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < COLS; c++) begin
        exp_q.push_back(fcell(0, start_row + r, c, cur_char));
        exp_q.push_back(fcell(1, start_row + r, c, cur_color));
      end
    end
    cpu_write(16'h6000, code);
    check(bus.busy == 1'b1, "busy_rise", 32'(bus.busy), 32'd1);
    check(bus.row_base == 6'(exp_base), "row_base_update", 32'(bus.row_base), 32'(exp_base));
    want = nrows * 2 * COLS + 1;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < want + 20) begin
      k++;
      if (inject && k == 5) begin
        bus.sys_addr = inj_addr;
        bus.sys_data = inj_data;
        bus.sys_we   = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.sys_we = 1'b0;
      seen = bus.done;
    end
    check(seen && k == want, "done_latency", 32'(k), 32'(want));
    @(posedge clk);
    #1;
    check(!bus.busy && !bus.done, "busy_fall", {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin : stim
    int base;
    int er, ec, ep, eng_left, cpu_n;
    bit early;
    logic [12:0] ca;
    logic [7:0]  cd;

    bus.sys_addr = 16'h0000;
    bus.sys_data = 8'h00;
    bus.sys_we   = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({bus.ram_we, bus.ram_addr, bus.ram_data} == 22'd0, "reset_ram_port",
          {10'd0, bus.ram_we, bus.ram_addr, bus.ram_data}, 32'd0);
    check({bus.row_base, bus.busy, bus.done} == 8'd0, "reset_status",
          {24'd0, bus.row_base, bus.busy, bus.done}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain cell write, row 2 col 5.
    cell_write(16'h4085, 8'h41, 13'h085);
    check(bus.row_base == 6'd0, "row_base_zero", 32'(bus.row_base), 32'd0);

    // CLRROW row 3.
    set_fill(8'h20, 8'h17);
    reg_write(REG_ROW_SEL, 8'd3);
    do_cmd(CMD_CLRROW, 3, 1, 0, 1'b0, 16'h0000, 8'h00);

    // 30 scrolls walk row_base round once; translation checked at base 29.
    base = 0;
    for (int i = 0; i < 30; i++) begin
      do_cmd(CMD_SCROLL, base, 1, (base + 1) % ROWS, 1'b0, 16'h0000, 8'h00);
      base = (base + 1) % ROWS;
      if (base == 29) begin
        cell_write(16'h4740, 8'h5A, 13'h0700);  // logical 29 -> physical 28
        cell_write(16'h5745, 8'h99, 13'h1705);  // colour plane, logical 29 col 5
        cell_write(16'h47C3, 8'h33, 13'h07C3);  // logical 31: untranslated
      end
    end
    cell_write(16'h4740, 8'h5B, 13'h0740);      // base 0 again: identity

    // CLEAR with a CPU cell write on every third cycle of the fill.
    do_cmd(CMD_SCROLL, 0, 1, 1, 1'b0, 16'h0000, 8'h00);
    set_fill(8'h2E, 8'h07);
    cpu_write(16'h6000, CMD_CLEAR);
    check(bus.row_base == 6'd0, "clear_row_base", 32'(bus.row_base), 32'd0);
    check(bus.busy == 1'b1, "clear_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    er = 0; ec = 0; ep = 0; eng_left = ROWS * COLS * 2; cpu_n = 0; early = 1'b0;
    for (int c = 0; eng_left > 0 && c < 3000; c++) begin
      if (c % 3 == 0 && cpu_n < 100) begin
        ca = {1'(cpu_n % 2), 6'(cpu_n % ROWS), 6'(cpu_n % COLS)};
        cd = 8'h80 + 8'(cpu_n);
        exp_q.push_back({ca, cd});
        bus.sys_addr = {3'b010, ca};
        bus.sys_data = cd;
        bus.sys_we   = 1'b1;
        cpu_n++;
      end else begin
        exp_q.push_back(fcell(ep, er, ec, (ep == 1) ? cur_color : cur_char));
        eng_left--;
        if (ep == 0) begin
          ep = 1;
        end else begin
          ep = 0;
          if (ec == COLS - 1) begin
            ec = 0;
            er++;
          end else begin
            ec++;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.sys_we = 1'b0;
      if (eng_left > 0 && bus.done) early = 1'b1;
    end
    check(!early, "clear_done_early", 32'(early), 32'd0);
    check(bus.done == 1'b1, "clear_done_slip", 32'(bus.done), 32'd1);
    @(posedge clk);
    #1;
    check(bus.busy == 1'b0, "clear_busy_fall", 32'(bus.busy), 32'd0);

    // CMD while busy is dropped: CLEAR injected during CLRROW must not reset row_base.
    do_cmd(CMD_SCROLL, 0, 1, 1, 1'b0, 16'h0000, 8'h00);
    reg_write(REG_ROW_SEL, 8'd3);
    do_cmd(CMD_CLRROW, 4, 1, 1, 1'b1, 16'h6000, CMD_CLEAR);
    check(bus.row_base == 6'd1, "busy_cmd_dropped", 32'(bus.row_base), 32'd1);

    // FILL_CHAR written mid-command does not affect it, but does affect the next one.
    do_cmd(CMD_CLRROW, 4, 1, 1, 1'b1, 16'h6001, 8'h55);
    cur_char = 8'h55;
    reg_write(REG_ROW_SEL, 8'd0);
    do_cmd(CMD_CLRROW, 1, 1, 1, 1'b0, 16'h0000, 8'h00);

    // Ignored commands: row out of range and an unknown code.
    reg_write(REG_ROW_SEL, 8'd30);
    reg_write(REG_CMD, CMD_CLRROW);
    check(bus.busy == 1'b0, "rowsel30_ignored", 32'(bus.busy), 32'd0);
    reg_write(REG_CMD, 8'h07);
    check(bus.busy == 1'b0, "cmd07_ignored", 32'(bus.busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check(bus.row_base == 6'd1 && !bus.busy, "ignored_no_change",
          {25'd0, bus.row_base, bus.busy}, {25'd0, 6'd1, 1'b0});

    // Reset in the middle of a CLEAR: nine writes, then nothing.
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(fcell(i % 2, 0, i / 2, (i % 2 == 1) ? cur_color : cur_char));
    end
    cpu_write(16'h6000, CMD_CLEAR);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check({bus.ram_we, bus.ram_addr, bus.ram_data, bus.busy, bus.done, bus.row_base} == 30'd0,
          "async_reset_outputs",
          {2'd0, bus.ram_we, bus.ram_addr, bus.ram_data, bus.busy, bus.done, bus.row_base}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check(bus.busy == 1'b0, "post_reset_idle", 32'(bus.busy), 32'd0);
    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
